// File: rtl/axi4aw_beat_gen.sv
// axi4aw_beat_gen: expands one AXI4 AW transaction into per-beat write address descriptors
module axi4aw_beat_gen #(
  parameter int ADDR_W = 32,
  parameter int ID_W = 1,
  parameter int MAX_SIZE = 2
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [ID_W-1:0]   beat_id,
  output logic [7:0]        beat_idx,
  output logic              beat_last,
  output logic              beat_err
);
  typedef enum logic {IDLE, BURST} state_t;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR = 2'b01;
  localparam logic [1:0] WRAP = 2'b10;
  localparam logic [2:0] MAX_S = 3'(MAX_SIZE);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  state_t state, state_nx;
  logic [7:0] len_q;
  logic [2:0] size_q, size_c;
  logic [1:0] mode_q, mode_c;
  logic [ADDR_W-1:0] wmask_q, wmask_c, bytes_c, last_c, bytes_q, inc_q, next_addr;
  logic aw_hs, beat_hs, wrap_len_ok, err_c;
  always_comb begin
    beat_valid = (state == BURST);
    beat_hs = beat_valid & beat_ready;
    awready = (state == IDLE) | (beat_hs & beat_last);
    aw_hs = awvalid & awready;
    state_nx = aw_hs ? BURST : (beat_hs & beat_last) ? IDLE : state;
    size_c = (awsize > MAX_S) ? MAX_S : awsize;
    bytes_c = ONE << size_c;
    wmask_c = ((ADDR_W'(awlen) + ONE) << size_c) - ONE;
    last_c = (awaddr & ~(bytes_c - ONE)) + wmask_c;
    wrap_len_ok = (awlen == 8'd1) | (awlen == 8'd3) | (awlen == 8'd7) | (awlen == 8'd15);
    mode_c = (awburst == 2'b11) ? FIXED : (awburst == WRAP && !wrap_len_ok) ? INCR : awburst;
    err_c = (awburst == 2'b11) | (awsize > MAX_S)
          | ((awburst == WRAP) & (!wrap_len_ok | (|(awaddr & (bytes_c - ONE)))))
          | ((awburst == INCR) & (last_c[ADDR_W-1:12] != awaddr[ADDR_W-1:12]));
    bytes_q = ONE << size_q;
    inc_q = (beat_addr & ~(bytes_q - ONE)) + bytes_q;
    next_addr = (mode_q == FIXED) ? beat_addr
              : (mode_q == WRAP) ? ((beat_addr & ~wmask_q) | (inc_q & wmask_q)) : inc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_addr <= '0;
      beat_id <= '0;
      beat_idx <= '0;
      beat_last <= 1'b0;
      beat_err <= 1'b0;
      len_q <= '0;
      size_q <= '0;
      mode_q <= FIXED;
      wmask_q <= '0;
    end else if (aw_hs) begin
      beat_addr <= awaddr;
      beat_id <= awid;
      beat_idx <= '0;
      beat_last <= (awlen == 8'd0);
      beat_err <= err_c;
      len_q <= awlen;
      size_q <= size_c;
      mode_q <= mode_c;
      wmask_q <= wmask_c;
    end else if (beat_hs && !beat_last) begin
      beat_addr <= next_addr;
      beat_idx <= beat_idx + 8'd1;
      beat_last <= (beat_idx + 8'd1 == len_q);
    end
  end
endmodule

// File: tb/tb_axi4aw_beat_gen.sv
// tb_axi4aw_beat_gen: directed self-checking bench for axi4aw_beat_gen
module tb_axi4aw_beat_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [0:0] awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0] awlen = '0;
  logic [2:0] awsize = '0;
  logic [1:0] awburst = '0;
  logic awvalid = 1'b0;
  logic awready, beat_valid;
  logic beat_ready = 1'b0;
  logic [31:0] beat_addr;
  logic [0:0] beat_id;
  logic [7:0] beat_idx;
  logic beat_last, beat_err;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  axi4aw_beat_gen #(.ADDR_W(32), .ID_W(1), .MAX_SIZE(2)) dut (
    .clk(clk), .rst_n(rst_n), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
    .beat_id(beat_id), .beat_idx(beat_idx), .beat_last(beat_last), .beat_err(beat_err)
  );
  task automatic issue_aw(input logic id, input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    awid = id;
    awaddr = a;
    awlen = l;
    awsize = s;
    awburst = b;
    awvalid = 1'b1;
  endtask
  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({beat_valid, awready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_hs got=%b exp=01", {beat_valid, awready});
    end
    checks++;
    if ({beat_addr, beat_id, beat_idx, beat_last, beat_err} !== 43'h0) begin
      failures++;
      $display("FAIL reset_desc got=%h exp=0", {beat_addr, beat_id, beat_idx, beat_last, beat_err});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_incr;
    logic [31:0] ea [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    issue_aw(1'b1, 32'h1000, 8'd3, 3'd2, 2'b01);
    beat_ready = 1'b1;
    #1;
    checks++;
    if (awready !== 1'b1) begin
      failures++;
      $display("FAIL incr_awready got=%b exp=1", awready);
    end
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if (beat_id !== 1'b1) begin
      failures++;
      $display("FAIL incr_id got=%b exp=1", beat_id);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({beat_valid, beat_addr, beat_idx, beat_last, beat_err} !== {1'b1, ea[i], 8'(i), i == 3, 1'b0}) begin
        failures++;
        $display("FAIL incr_beat%0d got=%h exp=%h", i, {beat_valid, beat_addr, beat_idx, beat_last, beat_err},
                 {1'b1, ea[i], 8'(i), i == 3, 1'b0});
      end
      awvalid = (i == 1 || i == 2);
      awaddr = 32'hDEAD0000;
      #1;
      checks++;
      if (awready !== (i == 3)) begin
        failures++;
        $display("FAIL incr_busy_awready%0d got=%b exp=%b", i, awready, i == 3);
      end
      @(negedge clk);
      awvalid = 1'b0;
    end
    checks++;
    if ({beat_valid, awready} !== 2'b01) begin
      failures++;
      $display("FAIL incr_idle got=%b exp=01", {beat_valid, awready});
    end
  endtask
  task automatic test_wrap;
    logic [31:0] ea [4] = '{32'h2008, 32'h200C, 32'h2000, 32'h2004};
    issue_aw(1'b0, 32'h2008, 8'd3, 3'd2, 2'b10);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({beat_valid, beat_addr, beat_idx, beat_last, beat_err} !== {1'b1, ea[i], 8'(i), i == 3, 1'b0}) begin
        failures++;
        $display("FAIL wrap_beat%0d got=%h exp=%h", i, {beat_valid, beat_addr, beat_idx, beat_last, beat_err},
                 {1'b1, ea[i], 8'(i), i == 3, 1'b0});
      end
      @(negedge clk);
    end
  endtask
  task automatic test_unaligned;
    logic [31:0] ea [3] = '{32'h3003, 32'h3004, 32'h3008};
    logic [31:0] eb [4] = '{32'h0FF8, 32'h0FFC, 32'h1000, 32'h1004};
    issue_aw(1'b0, 32'h3003, 8'd2, 3'd2, 2'b01);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({beat_valid, beat_addr, beat_idx, beat_last, beat_err} !== {1'b1, ea[i], 8'(i), i == 2, 1'b0}) begin
        failures++;
        $display("FAIL unal_beat%0d got=%h exp=%h", i, {beat_valid, beat_addr, beat_idx, beat_last, beat_err},
                 {1'b1, ea[i], 8'(i), i == 2, 1'b0});
      end
      @(negedge clk);
    end
    issue_aw(1'b0, 32'h0FF8, 8'd3, 3'd2, 2'b01);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({beat_valid, beat_addr, beat_idx, beat_last, beat_err} !== {1'b1, eb[i], 8'(i), i == 3, 1'b1}) begin
        failures++;
        $display("FAIL page_beat%0d got=%h exp=%h", i, {beat_valid, beat_addr, beat_idx, beat_last, beat_err},
                 {1'b1, eb[i], 8'(i), i == 3, 1'b1});
      end
      @(negedge clk);
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] eb [4] = '{32'h0600, 32'h0604, 32'h0608, 32'h060C};
    issue_aw(1'b0, 32'h0500, 8'd1, 3'd2, 2'b01);
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if ({beat_valid, beat_addr, beat_idx, beat_last} !== {1'b1, 32'h0500, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_a0 got=%h exp=%h", {beat_valid, beat_addr, beat_idx, beat_last}, {1'b1, 32'h0500, 8'd0, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({beat_valid, beat_addr, beat_idx, beat_last} !== {1'b1, 32'h0504, 8'd1, 1'b1}) begin
      failures++;
      $display("FAIL b2b_a1 got=%h exp=%h", {beat_valid, beat_addr, beat_idx, beat_last}, {1'b1, 32'h0504, 8'd1, 1'b1});
    end
    issue_aw(1'b1, 32'h0600, 8'd3, 3'd2, 2'b01);
    #1;
    checks++;
    if (awready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_awready got=%b exp=1", awready);
    end
    @(negedge clk);
    awvalid = 1'b0;
    beat_ready = 1'b0;
    checks++;
    if ({beat_valid, beat_addr, beat_id, beat_idx, beat_last} !== {1'b1, 32'h0600, 1'b1, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_b0 got=%h exp=%h", {beat_valid, beat_addr, beat_id, beat_idx, beat_last},
               {1'b1, 32'h0600, 1'b1, 8'd0, 1'b0});
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({beat_valid, awready, beat_addr, beat_id, beat_idx, beat_last, beat_err} !==
          {1'b1, 1'b0, 32'h0600, 1'b1, 8'd0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL stall%0d got=%h exp=%h", j, {beat_valid, awready, beat_addr, beat_id, beat_idx, beat_last, beat_err},
                 {1'b1, 1'b0, 32'h0600, 1'b1, 8'd0, 1'b0, 1'b0});
      end
    end
    beat_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({beat_valid, beat_addr, beat_idx, beat_last} !== {1'b1, eb[i], 8'(i), i == 3}) begin
        failures++;
        $display("FAIL b2b_b%0d got=%h exp=%h", i, {beat_valid, beat_addr, beat_idx, beat_last}, {1'b1, eb[i], 8'(i), i == 3});
      end
    end
    @(negedge clk);
    checks++;
    if (beat_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got=%b exp=0", beat_valid);
    end
  endtask
  task automatic test_illegal;
    logic [31:0] ca [3] = '{32'h0040, 32'h0100, 32'h0200};
    logic [1:0] cb [3] = '{2'b11, 2'b10, 2'b01};
    logic [2:0] cs [3] = '{3'd2, 3'd2, 3'd3};
    logic [7:0] cl [3] = '{8'd2, 8'd2, 8'd1};
    logic [31:0] ea [3][3] = '{'{32'h40, 32'h40, 32'h40}, '{32'h100, 32'h104, 32'h108}, '{32'h200, 32'h204, 32'h0}};
    for (int k = 0; k < 3; k++) begin
      issue_aw(1'b0, ca[k], cl[k], cs[k], cb[k]);
      @(negedge clk);
      awvalid = 1'b0;
      for (int i = 0; i <= int'(cl[k]); i++) begin
        checks++;
        if ({beat_valid, beat_addr, beat_idx, beat_last, beat_err} !== {1'b1, ea[k][i], 8'(i), i == int'(cl[k]), 1'b1}) begin
          failures++;
          $display("FAIL illegal%0d_beat%0d got=%h exp=%h", k, i, {beat_valid, beat_addr, beat_idx, beat_last, beat_err},
                   {1'b1, ea[k][i], 8'(i), i == int'(cl[k]), 1'b1});
        end
        @(negedge clk);
      end
    end
  endtask
  task automatic test_reset_mid;
    issue_aw(1'b1, 32'h4000, 8'd7, 3'd2, 2'b01);
    @(negedge clk);
    awvalid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({beat_valid, beat_addr, beat_idx} !== {1'b1, 32'h4008, 8'd2}) begin
      failures++;
      $display("FAIL rmid_pre got=%h exp=%h", {beat_valid, beat_addr, beat_idx}, {1'b1, 32'h4008, 8'd2});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({beat_valid, awready, beat_addr, beat_id, beat_idx, beat_last} !== {1'b0, 1'b1, 32'h0, 1'b0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL rmid_reset got=%h exp=%h", {beat_valid, awready, beat_addr, beat_id, beat_idx, beat_last},
               {1'b0, 1'b1, 32'h0, 1'b0, 8'd0, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue_aw(1'b0, 32'h5000, 8'd0, 3'd2, 2'b01);
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if ({beat_valid, beat_addr, beat_idx, beat_last, beat_err} !== {1'b1, 32'h5000, 8'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rmid_fresh got=%h exp=%h", {beat_valid, beat_addr, beat_idx, beat_last, beat_err},
               {1'b1, 32'h5000, 8'd0, 1'b1, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({beat_valid, awready} !== 2'b01) begin
      failures++;
      $display("FAIL rmid_idle got=%b exp=01", {beat_valid, awready});
    end
  endtask
  initial begin
    test_reset;
    test_incr;
    test_wrap;
    test_unaligned;
    test_back_to_back;
    test_illegal;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
